// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter.
//   DEPTH_DEF / MAX_CONSEC_DEF : default memory depth (words) and starvation limit
//   arb_state_e                : arbiter FSM encoding
//   port_e                     : requester identifiers
//   addr_in_range()            : unsigned word-address bounds check
package data_mem_pkg;

    localparam int unsigned DEPTH_DEF      = 1024;
    localparam int unsigned MAX_CONSEC_DEF = 4;

    typedef enum logic {
        ST_A_PRI   = 1'b0,
        ST_B_FORCE = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Full 32-bit unsigned compare, so wrapped/huge addresses never alias low words.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/data_mem_starve_ctr.sv
// Saturating count of consecutive A grants won while B is waiting.
//   clock, reset : clock and synchronous active-high reset
//   inc_i        : A won while B was requesting
//   clr_i        : restart the count (takes precedence over inc_i)
//   hit_o        : the count reaches MAX_CONSEC at this edge (combinational look-ahead)
module data_mem_starve_ctr #(
    parameter  int unsigned MAX_CONSEC = 4,
    localparam int unsigned CW         = $clog2(MAX_CONSEC + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(MAX_CONSEC))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Look at the next value so the FSM can switch to B_FORCE on the same edge
    // that the limit is reached, rather than one A grant later.
    assign hit_o = (cnt_d == CW'(MAX_CONSEC));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
//   clock, reset                 : clock, synchronous active-high reset
//   a_* (req/we/addr/wdata in)   : pipeline MEM-stage requester, default priority
//   a_gnt, a_rvalid, a_rdata,
//   a_err (out)                  : grant (comb), registered read response / range error
//   b_*                          : debug/DMA requester, same shape as port A
//   mem_read, mem_write,
//   mem_addr, mem_wdata (out)    : memory strobes and operands from the granted port
//   mem_rdata (in)               : combinational memory read data
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned MAX_CONSEC = MAX_CONSEC_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       gnt_a;
    logic       gnt_b;
    logic       cnt_inc;
    logic       cnt_clr;
    logic       cnt_hit;

    logic        any_gnt;
    port_e       sel_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_in_range;
    logic        rsp_vld;
    logic [31:0] rsp_data;

    logic        a_rvalid_q, a_rvalid_d;
    logic        a_err_q,    a_err_d;
    logic [31:0] a_rdata_q,  a_rdata_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic        b_err_q,    b_err_d;
    logic [31:0] b_rdata_q,  b_rdata_d;

    data_mem_starve_ctr #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_starve_ctr (
        .clock (clock),
        .reset (reset),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .hit_o (cnt_hit)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_A_PRI;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_A_PRI:   if (cnt_hit) state_d = ST_B_FORCE;
            // B_FORCE lasts one cycle whether B took the slot or had already gone away.
            ST_B_FORCE: state_d = ST_A_PRI;
            default:    state_d = ST_A_PRI;
        endcase
    end

    // ---- FSM: outputs (grants and counter control) ----
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_A_PRI: begin
                    if (a_req)      gnt_a = 1'b1;
                    else if (b_req) gnt_b = 1'b1;
                end
                ST_B_FORCE: begin
                    if (b_req)      gnt_b = 1'b1;
                    else if (a_req) gnt_a = 1'b1;
                end
                default: ;
            endcase
        end
        // Only an A win over a waiting B counts toward starvation; every other
        // outcome (B granted, B idle, forced slot) restarts the count.
        cnt_inc = (state_q == ST_A_PRI) && gnt_a && b_req;
        cnt_clr = !cnt_inc;
    end

    assign a_gnt = gnt_a;
    assign b_gnt = gnt_b;

    // Grant mux and range check
    always_comb begin
        any_gnt      = gnt_a | gnt_b;
        sel_port     = gnt_b ? PORT_B : PORT_A;
        sel_we       = (sel_port == PORT_B) ? b_we    : a_we;
        sel_addr     = (sel_port == PORT_B) ? b_addr  : a_addr;
        sel_wdata    = (sel_port == PORT_B) ? b_wdata : a_wdata;
        sel_in_range = addr_in_range(sel_addr, DEPTH);

        mem_read  = any_gnt & ~sel_we & sel_in_range;
        mem_write = any_gnt &  sel_we & sel_in_range;
        mem_addr  = any_gnt ? sel_addr  : '0;
        mem_wdata = any_gnt ? sel_wdata : '0;

        // A response is due for every read and for any out-of-range access
        // (the latter reports the error even for writes).
        rsp_vld  = any_gnt & (~sel_we | ~sel_in_range);
        rsp_data = mem_read ? mem_rdata : '0;

        a_rvalid_d = gnt_a & rsp_vld;
        a_err_d    = gnt_a & ~sel_in_range;
        a_rdata_d  = (gnt_a & rsp_vld) ? rsp_data : a_rdata_q;
        b_rvalid_d = gnt_b & rsp_vld;
        b_err_d    = gnt_b & ~sel_in_range;
        b_rdata_d  = (gnt_b & rsp_vld) ? rsp_data : b_rdata_q;
    end

    // ---- Response registers ----
    always_ff @(posedge clock) begin
        if (reset) begin
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            a_err_q    <= a_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_err_q    <= b_err_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // A response already registered when reset rises is squashed immediately.
    assign a_rvalid = a_rvalid_q & ~reset;
    assign a_err    = a_err_q    & ~reset;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q & ~reset;
    assign b_err    = b_err_q    & ~reset;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a reference arbiter model,
// a reference memory and per-port response scoreboards.
module tb_data_mem_arbiter;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned MAXC  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dut_mem [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t qa[$];
    rsp_t qb[$];

    bit m_state;
    int m_cnt;
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign mem_rdata = (mem_addr < DEPTH) ? dut_mem[mem_addr[9:0]] : 32'h0;

    data_mem_arbiter #(
        .DEPTH      (DEPTH),
        .MAX_CONSEC (MAXC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .a_err     (a_err),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .b_err     (b_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                         input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // One clock cycle: entered just after a falling edge with inputs driven.
    task automatic cycle();
        logic        ga, gb, we, inr, dw;
        logic [31:0] ad, wd, dwa, dwd;
        rsp_t        r;
        #1;
        if (reset) begin
            qa.delete();
            qb.delete();
        end
        if (qa.size() > 0) begin
            r = qa.pop_front();
            chk1("a_rvalid", a_rvalid, 1'b1);
            chk1("a_err", a_err, r.err);
            chk32("a_rdata", a_rdata, r.rdata);
        end else begin
            chk1("a_rvalid_quiet", a_rvalid, 1'b0);
        end
        if (qb.size() > 0) begin
            r = qb.pop_front();
            chk1("b_rvalid", b_rvalid, 1'b1);
            chk1("b_err", b_err, r.err);
            chk32("b_rdata", b_rdata, r.rdata);
        end else begin
            chk1("b_rvalid_quiet", b_rvalid, 1'b0);
        end

        ga = 1'b0;
        gb = 1'b0;
        if (!reset) begin
            if (!m_state) begin
                if (a_req) ga = 1'b1; else if (b_req) gb = 1'b1;
            end else begin
                if (b_req) gb = 1'b1; else if (a_req) ga = 1'b1;
            end
        end
        chk1("a_gnt", a_gnt, ga);
        chk1("b_gnt", b_gnt, gb);

        we  = gb ? b_we    : a_we;
        ad  = gb ? b_addr  : a_addr;
        wd  = gb ? b_wdata : a_wdata;
        inr = (ad < DEPTH);
        chk1("mem_read", mem_read, (ga | gb) & ~we & inr);
        chk1("mem_write", mem_write, (ga | gb) & we & inr);
        chk32("mem_addr", mem_addr, (ga | gb) ? ad : 32'h0);
        chk32("mem_wdata", mem_wdata, (ga | gb) ? wd : 32'h0);

        if ((ga | gb) && (!we || !inr)) begin
            r.err   = !inr;
            r.rdata = inr ? ref_mem[ad[9:0]] : 32'h0;
            if (ga) qa.push_back(r); else qb.push_back(r);
        end

        dw  = mem_write;
        dwa = mem_addr;
        dwd = mem_wdata;
        @(posedge clock);
        if (dw && (dwa < DEPTH)) dut_mem[dwa[9:0]] = dwd;
        if ((ga | gb) && we && inr) ref_mem[ad[9:0]] = wd;

        if (reset) begin
            m_state = 1'b0;
            m_cnt   = 0;
        end else if (!m_state) begin
            if (ga && b_req) begin
                m_cnt++;
                if (m_cnt == MAXC) m_state = 1'b1;
            end else begin
                m_cnt = 0;
            end
        end else begin
            m_cnt   = 0;
            m_state = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = 32'(i * 15 + 1);
            ref_mem[i] = 32'(i * 15 + 1);
        end
        m_state = 1'b0;
        m_cnt   = 0;
        idle();
        reset = 1'b1;
        @(negedge clock);

        // Reset: grants suppressed even with a request present, outputs cleared
        cycle();
        drive(1'b1, 1'b0, 32'd5, 32'h0, 1'b1, 1'b0, 32'd7, 32'h0);
        cycle();
        #1;
        chk32("a_rdata_reset", a_rdata, 32'h0);
        chk32("b_rdata_reset", b_rdata, 32'h0);
        idle();
        reset = 1'b0;
        cycle();

        // A read of mem[2] = 31, B stays quiet
        drive(1'b1, 1'b0, 32'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        idle();
        cycle();

        // B write then read back of address 6
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd6, 32'hDEAD_BEEF);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd6, 32'h0);
        cycle();
        idle();
        cycle();

        // Continuous contention: A,A,A,A,B repeating, back-to-back A reads
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 32'(10 + i), 32'h0, 1'b1, 1'b0, 32'd6, 32'h0);
            #1;
            chk1("pattern_b_gnt", b_gnt, (i % 5) == 4);
            cycle();
        end
        idle();
        cycle();

        // Range boundaries: last word in range, first and largest out of range
        drive(1'b1, 1'b0, 32'd1023, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        drive(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        cycle();
        // Out-of-range write: error pulse, no strobe, word 0 must not be touched
        drive(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        drive(1'b1, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        idle();
        cycle();
        chk32("word0_untouched", dut_mem[0], 32'd1);

        // Reset right after an A read grant while in B_FORCE: response dropped,
        // arbiter back to A priority with an empty starvation count
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'(20 + i), 32'h0, 1'b1, 1'b0, 32'd30, 32'h0);
            cycle();
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'(40 + i), 32'h0, 1'b1, 1'b0, 32'd50, 32'h0);
            #1;
            chk1("post_reset_a_gnt", a_gnt, (i % 5) != 4);
            cycle();
        end
        idle();
        cycle();

        // B released while in B_FORCE: A takes the slot, count restarted
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'(60 + i), 32'h0, 1'b1, 1'b0, 32'd70, 32'h0);
            cycle();
        end
        drive(1'b1, 1'b0, 32'd64, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk1("bforce_drop_a_gnt", a_gnt, 1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'(80 + i), 32'(32'hA000 + i), 1'b1, 1'b0, 32'd81, 32'h0);
            cycle();
        end
        idle();
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
